counter_seq: RTL and testbench

COUNTER_SEQ -- requirements
Module: counter_seq

---
 rtl/counter_seq_pkg.sv | 18 +
 rtl/counter_seq.sv | 112 +++++++++++
 tb/tb_counter_seq.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/counter_seq_pkg.sv
// Shared definitions for the index sequencer: state encoding and default widths.
package counter_seq_pkg;

    localparam int CNT_W_DEF  = 5;
    localparam int PASS_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic state_is_busy(input state_t s);
        return (s == ST_CLEAR) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/counter_seq.sv
// Multi-pass index sequencer driving an external count register (counter_mem):
// emits 0..cnt_max per pass with valid/ready handshaking, n_pass times.
module counter_seq
    import counter_seq_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int PASS_W = PASS_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  cnt_max,
    input  logic [PASS_W-1:0] n_pass,
    input  logic [CNT_W-1:0]  cnt_q,
    output logic [CNT_W-1:0]  cnt_next,
    output logic [CNT_W-1:0]  addr,
    output logic              valid,
    input  logic              ready,
    output logic              last,
    output logic              busy,
    output logic              done
);

    state_t            state;
    logic [CNT_W-1:0]  cnt_max_r;
    logic [PASS_W-1:0] n_pass_r;
    logic [PASS_W-1:0] pass;

    logic transfer;
    logic end_of_pass;
    logic final_pass;

    assign transfer    = valid && ready;
    // A count above the latched limit (corrupt feedback) also closes the pass.
    assign end_of_pass = (cnt_q >= cnt_max_r);
    assign final_pass  = (pass == (n_pass_r - PASS_W'(1)));

    assign addr = cnt_q;
    assign last = (state == ST_RUN) && end_of_pass && final_pass;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt_max_r <= '0;
            n_pass_r  <= PASS_W'(1);
            pass      <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort) begin
            state <= ST_IDLE;
            pass  <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= ST_CLEAR;
                        cnt_max_r <= cnt_max;
                        n_pass_r  <= (n_pass == '0) ? PASS_W'(1) : n_pass;
                        pass      <= '0;
                        busy      <= state_is_busy(ST_CLEAR);
                    end
                end
                ST_CLEAR: begin
                    state <= ST_RUN;
                    valid <= 1'b1;
                    busy  <= state_is_busy(ST_RUN);
                end
                ST_RUN: begin
                    if (transfer && end_of_pass) begin
                        if (final_pass) begin
                            state <= ST_DONE;
                            valid <= 1'b0;
                            busy  <= state_is_busy(ST_DONE);
                            done  <= 1'b1;
                        end else begin
                            pass <= pass + PASS_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Outside RUN the count register is flushed to zero every cycle.
    always_comb begin
        cnt_next = '0;
        if (!abort && (state == ST_RUN)) begin
            if (!transfer) begin
                cnt_next = cnt_q;
            end else if (!end_of_pass) begin
                cnt_next = cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_counter_seq.sv
// Bench for counter_seq: counter_mem modelled as a plain register, beats checked
// against an expected (addr, last) list built from cnt_max and n_pass.
module tb_counter_seq;
    import counter_seq_pkg::*;

    localparam int CNT_W  = 5;
    localparam int PASS_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  cnt_max;
    logic [PASS_W-1:0] n_pass;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_next;
    logic [CNT_W-1:0]  addr;
    logic              valid;
    logic              ready;
    logic              last;
    logic              busy;
    logic              done;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cnt_q <= cnt_next;

    counter_seq #(.CNT_W(CNT_W), .PASS_W(PASS_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .cnt_max  (cnt_max),
        .n_pass   (n_pass),
        .cnt_q    (cnt_q),
        .cnt_next (cnt_next),
        .addr     (addr),
        .valid    (valid),
        .ready    (ready),
        .last     (last),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, 32'(valid), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_done"}, 32'(done), 32'(0));
    endtask

    // mode 0: ready always high; 1: random ready and stray starts; 2: 3-cycle stall at addr 2
    task automatic run_seq(input int cmax, input int np, input int mode);
        logic [CNT_W-1:0] qa[$];
        bit               ql[$];
        int               npe;
        int               budget;
        int               stall_left;
        int               done_seen;
        npe        = (np == 0) ? 1 : np;
        stall_left = 3;
        done_seen  = 0;
        for (int p = 0; p < npe; p++)
            for (int i = 0; i <= cmax; i++) begin
                qa.push_back(CNT_W'(i));
                ql.push_back((p == npe - 1) && (i == cmax));
            end

        @(posedge clk); #1;
        cnt_max = CNT_W'(cmax);
        n_pass  = PASS_W'(np);
        start   = 1'b1;
        ready   = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'(0));
        chk("idle_cnt_next", 32'(cnt_next), 32'(0));

        @(posedge clk); #1;
        cnt_max = CNT_W'($urandom);
        n_pass  = PASS_W'($urandom);
        @(negedge clk);
        chk("clear_busy", 32'(busy), 32'(1));
        chk("clear_valid", 32'(valid), 32'(0));
        chk("clear_cnt_next", 32'(cnt_next), 32'(0));

        @(posedge clk); #1;
        start  = 1'b0;
        budget = 0;
        while (qa.size() > 0 && budget < 3000) begin
            case (mode)
                1: begin
                    ready = ($urandom_range(0, 3) != 0);
                    start = 1'($urandom_range(0, 1));
                end
                2: begin
                    if (qa[0] == CNT_W'(2) && stall_left > 0) begin
                        ready = 1'b0;
                        stall_left--;
                    end else begin
                        ready = 1'b1;
                    end
                end
                default: ready = 1'b1;
            endcase
            @(negedge clk);
            chk("run_valid", 32'(valid), 32'(1));
            chk("run_busy", 32'(busy), 32'(1));
            chk("run_addr", 32'(addr), 32'(qa[0]));
            if (ready) begin
                chk("run_last", 32'(last), 32'(ql[0]));
                void'(qa.pop_front());
                void'(ql.pop_front());
            end else begin
                chk("hold_cnt_next", 32'(cnt_next), 32'(qa[0]));
            end
            if (done) done_seen++;
            @(posedge clk); #1;
            budget++;
        end
        chk("beats_left", 32'(qa.size()), 32'(0));
        start = 1'b0;
        ready = 1'b1;

        @(negedge clk);
        chk("done_pulse", 32'(done), 32'(1));
        chk("done_valid", 32'(valid), 32'(0));
        chk("done_busy", 32'(busy), 32'(0));
        chk("done_cnt_next", 32'(cnt_next), 32'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk_idle_outputs("post_done");
        chk("early_done", 32'(done_seen), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        ready   = 1'b0;
        cnt_max = '0;
        n_pass  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        chk("reset_last", 32'(last), 32'(0));
        chk("reset_cnt_next", 32'(cnt_next), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("idle");
        chk("idle_cnt_q", 32'(cnt_q), 32'(0));

        run_seq(3, 1, 0);
        run_seq(1, 3, 0);
        run_seq(4, 1, 2);
        run_seq(0, 0, 0);
        run_seq(31, 1, 0);
        run_seq(31, 2, 1);

        // Abort at addr 2: no done pulse, count flushed.
        @(posedge clk); #1;
        cnt_max = CNT_W'(5);
        n_pass  = PASS_W'(1);
        start   = 1'b1;
        ready   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (valid && addr == CNT_W'(2)) break;
        end
        chk("abort_reach_addr", 32'(addr), 32'(2));
        abort = 1'b1;
        start = 1'b1;
        #1;
        chk("abort_cnt_next", 32'(cnt_next), 32'(0));
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk_idle_outputs("abort_next");
        chk("abort_cnt_q", 32'(cnt_q), 32'(0));
        repeat (4) begin
            @(negedge clk);
            chk_idle_outputs("abort_after");
        end

        // Reset mid-RUN: immediate reset values, no restart without a new start.
        @(posedge clk); #1;
        cnt_max = CNT_W'(6);
        n_pass  = PASS_W'(2);
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (valid && addr == CNT_W'(3)) break;
        end
        chk("rst_reach_addr", 32'(addr), 32'(3));
        #1;
        rst = 1'b1;
        #1;
        chk_idle_outputs("rst_mid");
        chk("rst_mid_last", 32'(last), 32'(0));
        chk("rst_mid_cnt_next", 32'(cnt_next), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk_idle_outputs("rst_after");
        end

        for (int k = 0; k < 8; k++)
            run_seq(int'($urandom_range(0, 31)), int'($urandom_range(0, 4)), 1);
        run_seq(2, 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
